// File: rtl/snake_pkg.sv
// snake_pkg: shared types, defaults and direction helper for the snake engine
package snake_pkg;
    localparam int DEF_GRID_W   = 64;
    localparam int DEF_GRID_H   = 48;
    localparam int DEF_MAX_LEN  = 32;
    localparam int DEF_INIT_LEN = 3;
    localparam int DEF_CELL_PX  = 10;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_UP    = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SCAN,
        S_COMMIT,
        S_DEAD
    } state_t;

    // Opposite directions differ only in the upper encoding bit.
    function automatic dir_t opposite(dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction
endpackage

// File: rtl/snake_render.sv
// snake_render: maps the VGA pixel to a grid cell and registers head/body/border hits
module snake_render
    import snake_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CELL_PX = DEF_CELL_PX,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [9:0]    px_i,
    input  logic [8:0]    py_i,
    input  logic [XW-1:0] seg_x_i [MAX_LEN],
    input  logic [YW-1:0] seg_y_i [MAX_LEN],
    input  logic [LW-1:0] length_i,
    output logic          pix_head_o,
    output logic          pix_body_o,
    output logic          pix_border_o
);
    logic [9:0] cx;
    logic [8:0] cy;
    logic       in_d, head_d, body_d, border_d;

    // Cell lookup and hit detection for the current pixel
    always_comb begin
        cx       = px_i / 10'(CELL_PX);
        cy       = py_i / 9'(CELL_PX);
        in_d     = int'(px_i) < GRID_W * CELL_PX && int'(py_i) < GRID_H * CELL_PX;
        head_d   = in_d && cx == 10'(seg_x_i[0]) && cy == 9'(seg_y_i[0]);
        border_d = in_d && (cx == 10'd0 || cx == 10'(GRID_W - 1) || cy == 9'd0 || cy == 9'(GRID_H - 1));
        body_d   = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            body_d = body_d | (in_d && LW'(i) < length_i && cx == 10'(seg_x_i[i]) && cy == 9'(seg_y_i[i]));
    end

    // Hits are registered, giving one cycle of pixel-to-output latency
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_head_o   <= 1'b0;
            pix_body_o   <= 1'b0;
            pix_border_o <= 1'b0;
        end else begin
            pix_head_o   <= head_d;
            pix_body_o   <= body_d;
            pix_border_o <= border_d;
        end
    end
endmodule

// File: rtl/snake_engine.sv
// snake_engine: snake game FSM with serial self-collision scan and segment store
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int INIT_LEN = DEF_INIT_LEN,
    parameter int CELL_PX  = DEF_CELL_PX,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          step_i,
    input  logic [1:0]    dir_i,
    input  logic [XW-1:0] apple_x_i,
    input  logic [YW-1:0] apple_y_i,
    input  logic [9:0]    px_i,
    input  logic [8:0]    py_i,
    output logic [XW-1:0] head_x_o,
    output logic [YW-1:0] head_y_o,
    output logic [LW-1:0] length_o,
    output logic          ate_o,
    output logic          game_over_o,
    output logic          busy_o,
    output logic          pix_head_o,
    output logic          pix_body_o,
    output logic          pix_border_o
);
    state_t        state_q;
    dir_t          cur_dir_q;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [LW-1:0] length_q, idx_q;
    logic [XW-1:0] nx_q;
    logic [YW-1:0] ny_q;
    logic          grow_q, apple_q, ate_q, game_over_q;

    dir_t          dir_d;
    logic [XW-1:0] nx_d;
    logic [YW-1:0] ny_d;
    logic [LW-1:0] last_d;
    logic          border_d, apple_hit_d, grow_d, seg_hit_d;

    // Candidate move, border/apple tests and the per-cycle segment compare
    always_comb begin
        dir_d       = dir_t'(dir_i) == opposite(cur_dir_q) ? cur_dir_q : dir_t'(dir_i);
        nx_d        = dir_d == DIR_RIGHT ? seg_x_q[0] + XW'(1) : dir_d == DIR_LEFT ? seg_x_q[0] - XW'(1) : seg_x_q[0];
        ny_d        = dir_d == DIR_DOWN  ? seg_y_q[0] + YW'(1) : dir_d == DIR_UP   ? seg_y_q[0] - YW'(1) : seg_y_q[0];
        border_d    = nx_d == '0 || nx_d == XW'(GRID_W - 1) || ny_d == '0 || ny_d == YW'(GRID_H - 1);
        apple_hit_d = nx_d == apple_x_i && ny_d == apple_y_i;
        grow_d      = apple_hit_d && length_q < LW'(MAX_LEN);
        // A growing move keeps the tail in place, so the tail joins the scan range
        last_d      = grow_q ? length_q - LW'(1) : length_q - LW'(2);
        seg_hit_d   = idx_q <= last_d && seg_x_q[idx_q[IW-1:0]] == nx_q && seg_y_q[idx_q[IW-1:0]] == ny_q;
    end

    // Game FSM, segment store and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cur_dir_q   <= DIR_RIGHT;
            length_q    <= '0;
            idx_q       <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            grow_q      <= 1'b0;
            apple_q     <= 1'b0;
            ate_q       <= 1'b0;
            game_over_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= '0;
                seg_y_q[i] <= '0;
            end
        end else begin
            ate_q <= 1'b0;
            if (!start_i) begin
                state_q     <= S_IDLE;
                length_q    <= '0;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            seg_x_q[i] <= XW'(GRID_W / 2 - i);
                            seg_y_q[i] <= YW'(GRID_H / 2);
                        end
                        length_q  <= LW'(INIT_LEN);
                        cur_dir_q <= DIR_RIGHT;
                        state_q   <= S_RUN;
                    end
                    S_RUN: if (step_i) begin
                        cur_dir_q   <= dir_d;
                        nx_q        <= nx_d;
                        ny_q        <= ny_d;
                        grow_q      <= grow_d;
                        apple_q     <= apple_hit_d;
                        idx_q       <= LW'(1);
                        state_q     <= border_d ? S_DEAD : S_SCAN;
                        game_over_q <= border_d;
                    end
                    S_SCAN: begin
                        if (seg_hit_d) begin
                            state_q     <= S_DEAD;
                            game_over_q <= 1'b1;
                        end else if (idx_q >= last_d) begin
                            state_q <= S_COMMIT;
                            ate_q   <= apple_q;
                        end else begin
                            idx_q <= idx_q + LW'(1);
                        end
                    end
                    S_COMMIT: begin
                        for (int i = MAX_LEN - 1; i > 0; i--) begin
                            seg_x_q[i] <= seg_x_q[i-1];
                            seg_y_q[i] <= seg_y_q[i-1];
                        end
                        seg_x_q[0] <= nx_q;
                        seg_y_q[0] <= ny_q;
                        length_q   <= length_q + LW'(grow_q);
                        state_q    <= S_RUN;
                    end
                    S_DEAD: state_q <= S_DEAD;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign head_x_o    = seg_x_q[0];
    assign head_y_o    = seg_y_q[0];
    assign length_o    = length_q;
    assign ate_o       = ate_q;
    assign game_over_o = game_over_q;
    assign busy_o      = state_q == S_SCAN || state_q == S_COMMIT;

    snake_render #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .MAX_LEN(MAX_LEN),
        .CELL_PX(CELL_PX)
    ) u_render (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .px_i        (px_i),
        .py_i        (py_i),
        .seg_x_i     (seg_x_q),
        .seg_y_i     (seg_y_q),
        .length_i    (length_q),
        .pix_head_o  (pix_head_o),
        .pix_body_o  (pix_body_o),
        .pix_border_o(pix_border_o)
    );
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed moves checked by a scoreboard monitor, plus render and reset checks
module tb_snake_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir = 2'b00;
    logic [3:0] apple_x = '0, apple_y = '0;
    logic [9:0] px = '0;
    logic [8:0] py = '0;
    logic [3:0] head_x, head_y, length;
    logic       ate, game_over, busy, pix_head, pix_body, pix_border;

    typedef struct {
        int x;
        int y;
        int len;
        int go;
        int ate;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    snake_engine #(
        .GRID_W(16), .GRID_H(12), .MAX_LEN(8), .INIT_LEN(3), .CELL_PX(10)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .step_i(step), .dir_i(dir),
        .apple_x_i(apple_x), .apple_y_i(apple_y), .px_i(px), .py_i(py),
        .head_x_o(head_x), .head_y_o(head_y), .length_o(length), .ate_o(ate),
        .game_over_o(game_over), .busy_o(busy), .pix_head_o(pix_head),
        .pix_body_o(pix_body), .pix_border_o(pix_border)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: a move completes when busy falls or game_over rises
    initial begin
        logic prev_busy, prev_go;
        int   ate_cnt;
        exp_t e;
        prev_busy = 1'b0;
        prev_go   = 1'b0;
        ate_cnt   = 0;
        forever begin
            @(negedge clk);
            if (ate) ate_cnt++;
            if ((prev_busy && !busy) || (!prev_go && game_over)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("head_x", int'(head_x), e.x);
                    chk("head_y", int'(head_y), e.y);
                    chk("length", int'(length), e.len);
                    chk("game_over", int'(game_over), e.go);
                    chk("ate_cycles", ate_cnt, e.ate);
                end
                ate_cnt = 0;
            end
            prev_busy = busy;
            prev_go   = game_over;
        end
    end

    task automatic move(input logic [1:0] d, input int x, input int y, input int len, input int go, input int a);
        sb.push_back('{x: x, y: y, len: len, go: go, ate: a});
        @(posedge clk); #1;
        dir  = d;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("move_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic restart();
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        chk("init_head_x", int'(head_x), 8);
        chk("init_head_y", int'(head_y), 6);
        chk("init_length", int'(length), 3);
    endtask

    task automatic pix(input int x, input int y, input int h, input int b, input int bd);
        @(posedge clk); #1;
        px = 10'(x);
        py = 9'(y);
        @(posedge clk);
        @(negedge clk);
        chk("pix_head", int'(pix_head), h);
        chk("pix_body", int'(pix_body), b);
        chk("pix_border", int'(pix_border), bd);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_head_x", int'(head_x), 0);
        chk("rst_head_y", int'(head_y), 0);
        chk("rst_length", int'(length), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ate", int'(ate), 0);
        chk("rst_pix", int'({pix_head, pix_body, pix_border}), 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        apple_x = 4'd9;
        apple_y = 4'd6;
        restart();
        pix(85, 65, 1, 0, 0);
        pix(79, 65, 0, 1, 0);
        pix(65, 65, 0, 1, 0);
        pix(55, 65, 0, 0, 0);
        pix(5, 65, 0, 0, 1);
        pix(155, 115, 0, 0, 1);
        pix(200, 65, 0, 0, 0);
        move(2'b00, 9, 6, 4, 0, 1);
        chk("busy_after_commit", int'(busy), 0);
        pix(95, 65, 1, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_length", int'(length), 0);
        chk("async_rst_game_over", int'(game_over), 0);
        chk("async_rst_pix", int'({pix_head, pix_body, pix_border}), 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        apple_x = 4'd0;
        apple_y = 4'd0;
        restart();
        move(2'b10, 9, 6, 3, 0, 0);
        restart();
        for (int i = 9; i <= 14; i++) move(2'b00, i, 6, 3, 0, 0);
        move(2'b00, 14, 6, 3, 1, 0);
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("dead_frozen_x", int'(head_x), 14);
        chk("dead_game_over", int'(game_over), 1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("stop_length", int'(length), 0);
        chk("stop_game_over", int'(game_over), 0);
        apple_x = 4'd9;
        apple_y = 4'd6;
        restart();
        move(2'b00, 9, 6, 4, 0, 1);
        apple_x = 4'd10;
        move(2'b00, 10, 6, 5, 0, 1);
        apple_x = 4'd0;
        apple_y = 4'd0;
        move(2'b01, 10, 5, 5, 0, 0);
        move(2'b10, 9, 5, 5, 0, 0);
        move(2'b11, 9, 5, 5, 1, 0);
        apple_x = 4'd9;
        apple_y = 4'd6;
        restart();
        move(2'b00, 9, 6, 4, 0, 1);
        apple_x = 4'd0;
        apple_y = 4'd0;
        move(2'b01, 9, 5, 4, 0, 0);
        move(2'b10, 8, 5, 4, 0, 0);
        move(2'b11, 8, 6, 4, 0, 0);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter GRID_W, default 64, meaning grid width in cells.
REQ-002 Parameter GRID_H, default 48, meaning grid height in cells.
REQ-003 Parameter MAX_LEN, default 32, meaning segment capacity.
REQ-004 Parameter INIT_LEN, default 3, meaning length at game start (2..MAX_LEN).
REQ-005 Parameter CELL_PX, default 10, meaning pixels per cell side.
REQ-006 clk  in  1  sole clock; reset  in  1  asynchronous, active-low.
REQ-007 start  in  1  level; 1 = game enabled, 0 = return to IDLE.
REQ-008 step  in  1  single-cycle move tick.
REQ-009 dir  in  2  requested direction: 00 right, 01 up, 10 left, 11 down.
REQ-010 apple_x/apple_y  in  clog2(GRID_W)/clog2(GRID_H)  apple cell.
REQ-011 px  in  10, py  in  9  current VGA pixel.
REQ-012 head_x/head_y  out  clog2(GRID_W)/clog2(GRID_H)  head cell.
REQ-013 length  out  clog2(MAX_LEN+1)  live segment count.
REQ-014 ate  out  1  one-cycle pulse on apple consumption.
REQ-015 game_over  out  1  level, set on lethal collision.
REQ-016 busy  out  1  high while a move is being evaluated.
REQ-017 pix_head, pix_body, pix_border  out  1 each  registered pixel hits.

Function
REQ-018 FSM states: IDLE, RUN, SCAN, COMMIT, DEAD.
REQ-019 IDLE, start=1: head=(GRID_W/2,GRID_H/2), segment i at (head_x-i,head_y), length=INIT_LEN, cur_dir=right -> RUN.
REQ-020 RUN, step=1: cur_dir<=dir unless dir is opposite of cur_dir (then retained); next head = head+1 cell in cur_dir.
REQ-021 Next head on border cell (x=0, x=GRID_W-1, y=0, y=GRID_H-1) -> DEAD, head unchanged; else -> SCAN, idx=1.
REQ-022 grow = (next head == apple) && length<MAX_LEN; apple at MAX_LEN = plain move, ate still pulses.
REQ-023 SCAN: one segment compared per cycle, idx 1..length-2 (..length-1 if grow); match -> DEAD; done -> COMMIT.
REQ-024 COMMIT: segments shift by one, seg[0]=next head; length+1 if grow; ate=1 this cycle on apple hit; -> RUN.
REQ-025 Step-to-head-update latency = length+1 cycles max; busy=1 in SCAN and COMMIT only.
REQ-026 step outside RUN, or while busy, is ignored (not queued).
REQ-027 DEAD: game_over=1, segments frozen; start=0 -> IDLE, clearing game_over and length.
REQ-028 start=0 in any state -> IDLE next cycle; length=0, game_over=0.
REQ-029 Render: pixel cell (px/CELL_PX, py/CELL_PX); pixels outside GRID_W*CELL_PX x GRID_H*CELL_PX give all hits 0.
REQ-030 pix_head = cell equals head; pix_body = cell equals any seg 1..length-1; pix_border = border cell; all registered, 1-cycle latency, non-exclusive.

Reset
REQ-031 reset=0: state IDLE, length 0, head (0,0), cur_dir right, ate/game_over/busy/pix_* = 0; segment storage need not be reset.

Structure
REQ-032 Package snake_pkg: dir_t enum, state_t enum, opposite-direction function, default parameter constants.
REQ-033 Sub-module snake_render holds pixel-to-cell mapping and hit registers; FSM and segment store stay in snake_engine.

Verification (GRID 16x12, MAX_LEN 8, INIT_LEN 3, CELL_PX 10; init head (8,6), body (7,6),(6,6))
REQ-034 Reset asserted mid-RUN -> length=0, game_over=0, pix_*=0 same cycle.
REQ-035 start, apple (9,6), step dir=right -> head (9,6), length 4, ate high exactly one cycle, busy low after COMMIT.
REQ-036 Fresh start, step dir=left -> reversal rejected, head (9,6).
REQ-037 Steps right x6 -> head (14,6); 7th step -> game_over=1, head stays (14,6).
REQ-038 Apples (9,6) then (10,6) -> length 5; steps up, left, down -> next head (9,6) hits seg 3 -> game_over; at length 4 same loop onto vacated tail -> no game_over.
REQ-039 Head (8,6): px=85,py=65 -> pix_head=1 one cycle later; px=79 -> 0; px=5,py=65 -> pix_border=1; px=200 -> all 0.
